player_motion_ctrl: RTL and testbench

Per-frame motion controller for the single on-screen character. It replaces the fixed character properties with registered position state, and is driven by left, right and jump buttons plus a once-per-frame tick. Internally it runs a ground/jump/fall state machine with integer gravity. It sits between the input synchroniser and the pixel renderer, and keeps the character property outputs so the renderer is unchanged.

---
 rtl/game_defs_pkg.sv | 20 ++
 rtl/player_motion_ctrl_if.sv | 28 ++
 rtl/player_jump_latch.sv | 32 +++
 rtl/player_motion_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/game_defs_pkg.sv
// Shared display/character constants and motion state encoding for the game pipeline.
package game_defs_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int CHAR_W       = 32;
    localparam int CHAR_H       = 60;
    localparam int FLOOR_OFFSET = 40;
    localparam int FLOOR_Y      = SCREEN_H - CHAR_H - FLOOR_OFFSET;

    localparam logic [7:0] CHAR_COLOR = 8'b11111110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_JUMP = 2'd2,
        ST_FALL = 2'd3
    } motion_state_e;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Button/tick inputs and character property outputs between input sync, motion control and renderer.
interface player_motion_ctrl_if;

    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] char_x_pos_out;
    logic [9:0] char_y_pos_out;
    logic [9:0] char_width_out;
    logic [9:0] char_height_out;
    logic [7:0] char_color_out_332;
    logic [1:0] state_out;
    logic       frame_done;

    modport master (
        output frame_tick, btn_left, btn_right, btn_jump,
        input  char_x_pos_out, char_y_pos_out, char_width_out, char_height_out,
        input  char_color_out_332, state_out, frame_done
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_jump,
        output char_x_pos_out, char_y_pos_out, char_width_out, char_height_out,
        output char_color_out_332, state_out, frame_done
    );

endinterface

// File: rtl/player_jump_latch.sv
// Jump button edge detector with a pending flag that survives until the next frame tick.
module player_jump_latch (
    input  logic clk,
    input  logic rst,
    input  logic btn_jump,
    input  logic frame_tick,
    output logic jump_req
);

    logic btn_q, btn_d;
    logic pending_q, pending_d;
    logic rise;

    always_comb begin
        rise      = btn_jump & ~btn_q;
        btn_d     = btn_jump;
        // An edge arriving with the tick is consumed by that tick via jump_req.
        pending_d = frame_tick ? 1'b0 : (pending_q | rise);
        jump_req  = pending_q | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            btn_q     <= btn_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame character motion: walk, jump and gravity fall with registered position outputs.
// Optional air jump is built when PLAYER_DOUBLE_JUMP_EN is defined.
module player_motion_ctrl #(
    parameter int         SCREEN_W     = game_defs_pkg::SCREEN_W,
    parameter int         SCREEN_H     = game_defs_pkg::SCREEN_H,
    parameter int         CHAR_W       = game_defs_pkg::CHAR_W,
    parameter int         CHAR_H       = game_defs_pkg::CHAR_H,
    parameter int         FLOOR_OFFSET = game_defs_pkg::FLOOR_OFFSET,
    parameter int         X_SPEED      = 4,
    parameter int         JUMP_V       = 12,
    parameter int         GRAVITY      = 1,
    parameter int         MAX_FALL_V   = 15,
    parameter logic [7:0] CHAR_COLOR   = game_defs_pkg::CHAR_COLOR
) (
    input logic                 clk,
    input logic                 rst,
    player_motion_ctrl_if.slave bus
);

    import game_defs_pkg::*;

    localparam logic [9:0]         X_START   = 10'((SCREEN_W - CHAR_W) / 2);
    localparam logic [9:0]         Y_FLOOR   = 10'(SCREEN_H - CHAR_H - FLOOR_OFFSET);
    localparam logic signed [10:0] X_MAX_S   = 11'(SCREEN_W - CHAR_W);
    localparam logic signed [10:0] DX_STEP   = 11'(X_SPEED);
    localparam logic signed [11:0] Y_FLOOR_S = 12'(SCREEN_H - CHAR_H - FLOOR_OFFSET);
    localparam logic signed [11:0] JUMP_V_S  = 12'(JUMP_V);
    localparam logic signed [5:0]  VY_LAUNCH = 6'(GRAVITY - JUMP_V);
    localparam logic signed [6:0]  GRAV_S    = 7'(GRAVITY);
    localparam logic signed [6:0]  VMAX_S    = 7'(MAX_FALL_V);

    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic signed [5:0] vy_q, vy_d;
    motion_state_e     state_q, state_d;
    logic              tick_q, tick_d;
    logic              jump_take_q, jump_take_d;
    logic [1:0]        dir_q, dir_d;
    logic              frame_done_q, frame_done_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic              air_used_q, air_used_d;
`endif

    logic               jump_req;
    logic               walk_req;
    logic               grounded;
    logic               air_launch;
    logic signed [10:0] dx;
    logic signed [10:0] x_n;
    logic signed [11:0] y_n;
    logic signed [11:0] y_launch;
    logic signed [6:0]  vy_inc;

    player_jump_latch u_jump_latch (
        .clk        (clk),
        .rst        (rst),
        .btn_jump   (bus.btn_jump),
        .frame_tick (bus.frame_tick),
        .jump_req   (jump_req)
    );

    // Inputs are snapshotted on the tick edge and applied one edge later.
    always_comb begin
        tick_d       = bus.frame_tick;
        jump_take_d  = bus.frame_tick & jump_req;
        dir_d        = {bus.btn_left, bus.btn_right};
        x_d          = x_q;
        y_d          = y_q;
        vy_d         = vy_q;
        state_d      = state_q;
        frame_done_d = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
        air_used_d   = air_used_q;
        air_launch   = jump_take_q & ~air_used_q;
`else
        air_launch   = 1'b0;
`endif

        walk_req = dir_q[0] ^ dir_q[1];
        grounded = (state_q == ST_IDLE) || (state_q == ST_WALK);
        if (dir_q == 2'b01)
            dx = DX_STEP;
        else if (dir_q == 2'b10)
            dx = -DX_STEP;
        else
            dx = '0;
        x_n      = $signed({1'b0, x_q}) + dx;
        y_n      = $signed({2'b00, y_q}) + $signed({{6{vy_q[5]}}, vy_q});
        y_launch = $signed({2'b00, y_q}) - JUMP_V_S;
        vy_inc   = $signed({vy_q[5], vy_q}) + GRAV_S;

        if (tick_q) begin
            frame_done_d = 1'b1;
            if (x_n[10])
                x_d = '0;
            else if (x_n > X_MAX_S)
                x_d = X_MAX_S[9:0];
            else
                x_d = x_n[9:0];

            if ((grounded && jump_take_q) || (!grounded && air_launch)) begin
                y_d     = y_launch[11] ? '0 : y_launch[9:0];
                vy_d    = VY_LAUNCH;
                state_d = ST_JUMP;
`ifdef PLAYER_DOUBLE_JUMP_EN
                if (!grounded)
                    air_used_d = 1'b1;
`endif
            end else begin
                case (state_q)
                    ST_IDLE, ST_WALK: begin
                        state_d = walk_req ? ST_WALK : ST_IDLE;
                    end
                    ST_JUMP: begin
                        if (y_n[11]) begin
                            y_d     = '0;
                            vy_d    = '0;
                            state_d = ST_FALL;
                        end else begin
                            y_d  = y_n[9:0];
                            vy_d = vy_inc[5:0];
                            if (!vy_inc[6])
                                state_d = ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        if (y_n >= Y_FLOOR_S) begin
                            y_d     = Y_FLOOR;
                            vy_d    = '0;
                            state_d = walk_req ? ST_WALK : ST_IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            air_used_d = 1'b0;
`endif
                        end else begin
                            y_d  = y_n[9:0];
                            vy_d = (vy_inc > VMAX_S) ? VMAX_S[5:0] : vy_inc[5:0];
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= X_START;
            y_q          <= Y_FLOOR;
            vy_q         <= '0;
            state_q      <= ST_IDLE;
            tick_q       <= 1'b0;
            jump_take_q  <= 1'b0;
            dir_q        <= '0;
            frame_done_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_used_q   <= 1'b0;
`endif
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            vy_q         <= vy_d;
            state_q      <= state_d;
            tick_q       <= tick_d;
            jump_take_q  <= jump_take_d;
            dir_q        <= dir_d;
            frame_done_q <= frame_done_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_used_q   <= air_used_d;
`endif
        end
    end

    always_comb begin
        bus.char_x_pos_out     = x_q;
        bus.char_y_pos_out     = y_q;
        bus.char_width_out     = 10'(CHAR_W);
        bus.char_height_out    = 10'(CHAR_H);
        bus.char_color_out_332 = CHAR_COLOR;
        bus.state_out          = state_q;
        bus.frame_done         = frame_done_q;
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl; expectations follow PLAYER_DOUBLE_JUMP_EN when defined.
module tb_player_motion_ctrl;

    import game_defs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    player_motion_ctrl_if bus();

    player_motion_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_total++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey, input int est);
        check_eq({tag, ".x"}, 32'(bus.char_x_pos_out), ex);
        check_eq({tag, ".y"}, 32'(bus.char_y_pos_out), ey);
        check_eq({tag, ".st"}, 32'(bus.state_out), est);
    endtask

    // Tick high for one cycle; returns #1 after the edge where results land.
    task automatic tick_frame(input logic with_jump);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        if (with_jump) bus.btn_jump = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.btn_jump   = 1'b0;
        @(posedge clk);
        #1;
        check_eq("done", 32'(bus.frame_done), 1);
    endtask

    task automatic pulse_jump();
        @(negedge clk);
        bus.btn_jump = 1'b1;
        @(negedge clk);
        bus.btn_jump = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int jump_y[25];
        int ex;
        jump_y = '{368, 357, 347, 338, 330, 323, 317, 312, 308, 305, 303, 302,
                   302, 303, 305, 308, 312, 317, 323, 330, 338, 347, 357, 368, 380};

        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_jump   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_pos("reset", 304, 380, int'(ST_IDLE));
        check_eq("reset.done", 32'(bus.frame_done), 0);
        check_eq("width", 32'(bus.char_width_out), 32);
        check_eq("height", 32'(bus.char_height_out), 60);
        check_eq("color", 32'(bus.char_color_out_332), 254);

        for (int i = 0; i < 3; i++) begin
            tick_frame(1'b0);
            check_pos("idle", 304, 380, int'(ST_IDLE));
            @(posedge clk);
            #1;
            check_eq("done.pulse", 32'(bus.frame_done), 0);
        end

        bus.btn_right = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            tick_frame(1'b0);
            ex = (304 + 4 * k > 608) ? 608 : 304 + 4 * k;
            check_pos("right", ex, 380, int'(ST_WALK));
        end
        bus.btn_right = 1'b0;

        bus.btn_left = 1'b1;
        for (int k = 1; k <= 160; k++) begin
            tick_frame(1'b0);
            ex = (608 - 4 * k < 0) ? 0 : 608 - 4 * k;
            check_eq("left.x", 32'(bus.char_x_pos_out), ex);
        end
        check_eq("left.st", 32'(bus.state_out), int'(ST_WALK));

        bus.btn_right = 1'b1;
        tick_frame(1'b0);
        check_pos("both", 0, 380, int'(ST_IDLE));
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;

        pulse_jump();
        for (int k = 1; k <= 25; k++) begin
            tick_frame(1'b0);
            check_pos("jump", 0, jump_y[k-1],
                      (k <= 11) ? int'(ST_JUMP) : (k <= 24) ? int'(ST_FALL) : int'(ST_IDLE));
        end

        tick_frame(1'b1);
        check_pos("jump_same", 0, 368, int'(ST_JUMP));
        repeat (24) tick_frame(1'b0);
        check_pos("jump_same.land", 0, 380, int'(ST_IDLE));

        @(negedge clk);
        bus.btn_right  = 1'b1;
        bus.frame_tick = 1'b1;
        repeat (3) @(negedge clk);
        bus.frame_tick = 1'b0;
        @(posedge clk);
        #1;
        check_pos("b2b", 12, 380, int'(ST_WALK));
        check_eq("b2b.done", 32'(bus.frame_done), 1);
        bus.btn_right = 1'b0;
        tick_frame(1'b0);

        pulse_jump();
        repeat (5) tick_frame(1'b0);
        check_pos("prerst", 12, 330, int'(ST_JUMP));
        @(negedge clk);
        bus.btn_jump = 1'b1;
        @(negedge clk);
        bus.btn_jump = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_pos("midrst", 304, 380, int'(ST_IDLE));
        check_eq("midrst.done", 32'(bus.frame_done), 0);
        tick_frame(1'b0);
        check_pos("midrst.pend", 304, 380, int'(ST_IDLE));

        pulse_jump();
        repeat (5) tick_frame(1'b0);
        check_pos("dj5", 304, 330, int'(ST_JUMP));
        pulse_jump();
        tick_frame(1'b0);
`ifdef PLAYER_DOUBLE_JUMP_EN
        check_pos("dj6", 304, 318, int'(ST_JUMP));
        tick_frame(1'b0);
        check_pos("dj7", 304, 307, int'(ST_JUMP));
        pulse_jump();
        tick_frame(1'b0);
        check_pos("dj8", 304, 297, int'(ST_JUMP));
`else
        check_pos("dj6", 304, 323, int'(ST_JUMP));
        tick_frame(1'b0);
        check_pos("dj7", 304, 317, int'(ST_JUMP));
        pulse_jump();
        tick_frame(1'b0);
        check_pos("dj8", 304, 312, int'(ST_JUMP));
`endif
        repeat (40) tick_frame(1'b0);
        check_pos("dj.land", 304, 380, int'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
